instr_fetch: RTL and testbench

- Fetch stage directly downstream of the PC generator.
- Accepts one fetch PC per cycle and issues a word request to instruction memory.
- Tracks outstanding requests and buffers each returned instruction with its PC in an in-order instruction queue (IQ) for decode.
- On redirect (flush) it empties the IQ and discards responses to requests issued before the flush.

---
 rtl/instr_fetch_pkg.sv | 10 +
 rtl/instr_fetch_if.sv | 30 +++
 rtl/instr_fetch_fifo.sv | 51 +++++
 rtl/instr_fetch.sv | 133 +++++++++++++
 tb/tb_instr_fetch.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_fetch_pkg.sv
// rtl/instr_fetch_pkg.sv - shared widths and instruction-queue entry type for the fetch stage
package instr_fetch_pkg;
    localparam int XLEN = 64;
    localparam int ILEN = 32;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } iq_entry_t;
endpackage

// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - PC-generator, imem and decode handshakes of the fetch stage
interface instr_fetch_if;
    import instr_fetch_pkg::*;

    logic [XLEN-1:0] fetch_pc;
    logic            fetch_vaild;
    logic            fetch_ready;
    logic            flush;
    logic            imem_req_valid;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_req_ready;
    logic            imem_rsp_valid;
    logic [ILEN-1:0] imem_rsp_data;
    logic            instr_valid;
    logic [ILEN-1:0] instr;
    logic [XLEN-1:0] instr_pc;
    logic            instr_ready;
    logic            iq_full;
    logic            iq_empty;

    modport master (
        output fetch_pc, fetch_vaild, flush, imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
        input  fetch_ready, imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc, iq_full, iq_empty
    );

    modport slave (
        input  fetch_pc, fetch_vaild, flush, imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
        output fetch_ready, imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc, iq_full, iq_empty
    );
endinterface

// File: rtl/instr_fetch_fifo.sv
// rtl/instr_fetch_fifo.sv - power-of-two FIFO with flush; push and pop together are legal even when full
module instr_fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [CW-1:0]    o_count
);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + PTR_ONE;
            if (i_pop)  r_rptr <= r_rptr + PTR_ONE;
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (i_push && !i_flush) r_mem[r_wptr] <= i_data;
    end

    // Head reads as zero when empty so the outputs carry clean values out of reset
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_count = r_count;
    assign o_data  = o_empty ? '0 : r_mem[r_rptr];
endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - fetch stage: request register, in-flight PC FIFO, instruction queue.
// IFETCH_BYPASS_EN adds a zero-latency response-to-decode path when the IQ is empty.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int IQ_DEPTH        = 4,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic         clk,
    input  logic         RST,
    instr_fetch_if.slave bus
);
    localparam int CW = $clog2(IQ_DEPTH + 1);
    localparam int SW = CW + 2;

    logic            r_req_valid;
    logic [XLEN-1:0] r_req_addr;
    logic [CW-1:0]   r_drop;

    logic            w_fetch_fire;
    logic            w_issue;
    logic            w_rsp;
    logic            w_pcf_pop;
    logic            w_keep;
    logic            w_iq_push;
    logic            w_iq_pop;
    logic            w_pcf_empty;
    logic            w_pcf_full;
    logic            w_iq_empty;
    logic            w_iq_full;
    logic [CW-1:0]   w_out_cnt;
    logic [CW-1:0]   w_out_next;
    logic [CW-1:0]   w_iq_cnt;
    logic [SW-1:0]   w_credit;
    logic [XLEN-1:0] w_rsp_pc;
    iq_entry_t       w_iq_in;
    iq_entry_t       w_iq_head;
    iq_entry_t       w_out_entry;

    assign w_issue   = r_req_valid & bus.imem_req_ready;
    assign w_rsp     = bus.imem_rsp_valid;
    assign w_pcf_pop = w_rsp & ~w_pcf_empty;
    assign w_credit  = SW'(r_req_valid) + SW'(w_out_cnt) + SW'(w_iq_cnt);

    // The credit term reserves an IQ slot for every request in REQ or in flight
    assign bus.fetch_ready = ~RST & ~bus.flush
                           & (~r_req_valid | bus.imem_req_ready)
                           & (w_out_cnt < CW'(MAX_OUTSTANDING))
                           & (w_credit < SW'(IQ_DEPTH));
    assign w_fetch_fire = bus.fetch_vaild & bus.fetch_ready;

    assign bus.imem_req_valid = r_req_valid;
    assign bus.imem_req_addr  = r_req_addr;

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_req_valid <= 1'b0;
            r_req_addr  <= '0;
        end else if (bus.flush) begin
            r_req_valid <= 1'b0;
        end else if (w_fetch_fire) begin
            r_req_valid <= 1'b1;
            r_req_addr  <= bus.fetch_pc;
        end else if (w_issue) begin
            r_req_valid <= 1'b0;
        end
    end

    // Responses still owed to pre-flush requests, including one issued in the flush cycle
    assign w_out_next = w_out_cnt + CW'(w_issue) - CW'(w_pcf_pop);

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_drop <= '0;
        end else if (bus.flush) begin
            r_drop <= w_out_next;
        end else if (w_rsp && r_drop != '0) begin
            r_drop <= r_drop - CW'(1);
        end
    end

    assign w_keep  = w_rsp & ~bus.flush & (r_drop == '0);
    assign w_iq_in = '{pc: w_rsp_pc, instr: bus.imem_rsp_data};

    // Sized by IQ_DEPTH: a request can issue the cycle after OUT reaches MAX_OUTSTANDING
    instr_fetch_fifo #(.WIDTH(XLEN), .DEPTH(IQ_DEPTH)) u_pc_fifo (
        .clk     (clk),
        .rst     (RST),
        .i_push  (w_issue),
        .i_data  (r_req_addr),
        .i_pop   (w_pcf_pop),
        .i_flush (1'b0),
        .o_data  (w_rsp_pc),
        .o_full  (w_pcf_full),
        .o_empty (w_pcf_empty),
        .o_count (w_out_cnt)
    );

    instr_fetch_fifo #(.WIDTH($bits(iq_entry_t)), .DEPTH(IQ_DEPTH)) u_iq (
        .clk     (clk),
        .rst     (RST),
        .i_push  (w_iq_push),
        .i_data  (w_iq_in),
        .i_pop   (w_iq_pop),
        .i_flush (bus.flush),
        .o_data  (w_iq_head),
        .o_full  (w_iq_full),
        .o_empty (w_iq_empty),
        .o_count (w_iq_cnt)
    );

`ifdef IFETCH_BYPASS_EN
    logic w_bypass;
    assign w_bypass        = w_keep & w_iq_empty;
    assign w_iq_push       = w_keep & ~(w_bypass & bus.instr_ready);
    assign w_iq_pop        = ~w_iq_empty & bus.instr_ready;
    assign bus.instr_valid = ~w_iq_empty | w_bypass;
    assign w_out_entry     = w_bypass ? w_iq_in : w_iq_head;
`else
    assign w_iq_push       = w_keep;
    assign w_iq_pop        = ~w_iq_empty & bus.instr_ready;
    assign bus.instr_valid = ~w_iq_empty;
    assign w_out_entry     = w_iq_head;
`endif

    assign bus.instr    = w_out_entry.instr;
    assign bus.instr_pc = w_out_entry.pc;
    assign bus.iq_full  = w_iq_full;
    assign bus.iq_empty = w_iq_empty;

    assert property (@(posedge clk) disable iff (RST) w_rsp |-> !w_pcf_empty);
    assert property (@(posedge clk) disable iff (RST) w_issue |-> (!w_pcf_full || w_pcf_pop));
endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed scoreboard bench for instr_fetch with an in-order imem model
module tb_instr_fetch;
    import instr_fetch_pkg::*;

    localparam int IQ_DEPTH = 4;
    localparam int MAX_OUT  = 2;

    typedef struct {
        logic [63:0] pc;
        int          due;
        bit          stale;
    } mem_t;

    logic clk = 1'b0;
    logic RST = 1'b1;
    always #5 clk = ~clk;

    instr_fetch_if bus();

    instr_fetch #(.IQ_DEPTH(IQ_DEPTH), .MAX_OUTSTANDING(MAX_OUT)) dut (
        .clk (clk),
        .RST (RST),
        .bus (bus)
    );

    int          vectors = 0;
    int          miscompares = 0;
    mem_t        mem_q[$];
    logic [63:0] fetch_q[$];
    iq_entry_t   sb[$];
    int          cyc = 0;
    int          rsp_lat = 2;
    int          pops = 0;
    int          fires = 0;
    bit          prev_fire = 0;
    logic [63:0] prev_pc = '0;
    bit          k_fv = 0, k_req_rdy = 0, k_pop = 0, k_flush = 0;
    logic [63:0] k_pc = '0;

    function automatic logic [31:0] mem_data(input logic [63:0] pc);
        case (pc)
            64'h8000_0000: return 32'h0000_0013;
            64'h8000_0004: return 32'h0010_0093;
            default:       return {pc[15:0], 16'h0013} ^ 32'h0505_0000;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_valid"}, bus.imem_req_valid, 1'b0);
        chk({tag, "_req_addr"},  bus.imem_req_addr, 64'h0);
        chk({tag, "_instr_valid"}, bus.instr_valid, 1'b0);
        chk({tag, "_instr"},     bus.instr, 32'h0);
        chk({tag, "_instr_pc"},  bus.instr_pc, 64'h0);
        chk({tag, "_iq_empty"},  bus.iq_empty, 1'b1);
        chk({tag, "_iq_full"},   bus.iq_full, 1'b0);
        chk({tag, "_fetch_ready"}, bus.fetch_ready, 1'b0);
    endtask

    // One clock cycle: entered and left at the falling edge
    task automatic tick();
        int          n;
        bit          rsp, fire, issue, pop, exp_ready;
        mem_t        m;
        logic [63:0] rpc;
        iq_entry_t   e;
        n = sb.size();
        rsp = (mem_q.size() != 0) && (mem_q[0].due <= cyc);
        bus.fetch_vaild    = k_fv;
        bus.fetch_pc       = k_pc;
        bus.imem_req_ready = k_req_rdy;
        bus.instr_ready    = k_pop;
        bus.flush          = k_flush;
        bus.imem_rsp_valid = rsp;
        bus.imem_rsp_data  = rsp ? mem_data(mem_q[0].pc) : 32'h0;
        #3;
        if (prev_fire) begin
            chk("req_latency_valid", bus.imem_req_valid, 1'b1);
            chk("req_latency_addr", bus.imem_req_addr, prev_pc);
        end
        if (bus.imem_req_valid) begin
            if (fetch_q.size() == 0) chk("req_unexpected", bus.imem_req_valid, 1'b0);
            else chk("req_addr", bus.imem_req_addr, fetch_q[0]);
        end
        chk("iq_empty", bus.iq_empty, n == 0);
        chk("iq_full", bus.iq_full, n == IQ_DEPTH);
        exp_ready = !k_flush && (fetch_q.size() == 0 || k_req_rdy) && (mem_q.size() < MAX_OUT)
                    && ((fetch_q.size() + mem_q.size() + n) < IQ_DEPTH);
        chk("fetch_ready", bus.fetch_ready, exp_ready);
        fire  = k_fv && bus.fetch_ready;
        issue = bus.imem_req_valid && k_req_rdy;
        pop   = bus.instr_valid && k_pop;
        if (rsp) begin
            m = mem_q.pop_front();
            if (!m.stale && !k_flush) sb.push_back('{pc: m.pc, instr: mem_data(m.pc)});
        end
        if (issue) begin
            rpc = (fetch_q.size() != 0) ? fetch_q.pop_front() : 64'h0;
            mem_q.push_back('{pc: rpc, due: cyc + rsp_lat, stale: k_flush});
        end
        if (pop) begin
            pops++;
            if (sb.size() == 0) begin
                chk("pop_unexpected", bus.instr_valid, 1'b0);
            end else begin
                e = sb.pop_front();
                chk("instr", bus.instr, e.instr);
                chk("instr_pc", bus.instr_pc, e.pc);
            end
        end
        if (k_flush) begin
            foreach (mem_q[i]) mem_q[i].stale = 1'b1;
            fetch_q.delete();
            sb.delete();
        end
        if (fire) begin
            fetch_q.push_back(k_pc);
            fires++;
        end
        prev_fire = fire;
        prev_pc   = k_pc;
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic drain();
        k_fv = 0;
        k_pop = 1;
        k_req_rdy = 1;
        for (int i = 0; i < 40; i++) begin
            if (sb.size() == 0 && mem_q.size() == 0 && fetch_q.size() == 0) break;
            tick();
        end
        chk("drain_empty", sb.size() + mem_q.size() + fetch_q.size(), 0);
    endtask

    initial begin
        int p0, f0, found;
        bus.fetch_vaild = 1'b1;
        bus.fetch_pc = 64'h8000_0000;
        bus.flush = 1'b0;
        bus.imem_req_ready = 1'b1;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data = 32'h0;
        bus.instr_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk_reset_outputs("reset");
        RST = 1'b0;

        // Two fetches, decoded in order with the fixed instruction words
        p0 = pops;
        k_req_rdy = 1; k_pop = 1; rsp_lat = 2;
        k_fv = 1; k_pc = 64'h8000_0000; tick();
        k_pc = 64'h8000_0004; tick();
        drain();
        chk("t1_pops", pops - p0, 2);

        // Memory stalls for 5 cycles with a second fetch waiting
        p0 = pops;
        k_req_rdy = 0;
        k_fv = 1; k_pc = 64'h8000_0010; tick();
        k_pc = 64'h8000_0014;
        repeat (5) tick();
        chk("t2_single_req", fetch_q.size(), 1);
        drain();
        chk("t2_pops", pops - p0, 1);

        // Decode stalled: at most IQ_DEPTH fetches accepted, then drain with concurrent traffic
        p0 = pops; f0 = fires;
        k_pop = 0; k_req_rdy = 1; k_fv = 1; k_pc = 64'h8000_0200;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (prev_fire) k_pc += 4;
        end
        chk("t3_accepted", fires - f0, IQ_DEPTH);
        chk("t3_iq_full", bus.iq_full, 1'b1);
        chk("t3_fetch_ready", bus.fetch_ready, 1'b0);
        k_pop = 1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (prev_fire) k_pc += 4;
        end
        drain();
        chk("t3_no_loss", pops - p0, fires - f0);

        // Flush with two in flight, then a new fetch
        p0 = pops;
        rsp_lat = 4;
        k_fv = 1; k_pc = 64'h8000_0300; tick();
        k_pc = 64'h8000_0304; tick();
        k_fv = 0; tick();
        chk("t4_in_flight", mem_q.size(), 2);
        k_flush = 1; tick();
        k_flush = 0; k_fv = 1; k_pc = 64'h8000_0100; tick();
        for (int i = 0; i < 10 && !prev_fire; i++) tick();
        drain();
        chk("t4_pops", pops - p0, 1);

        // Flush on a response cycle, then again while one drop is pending
        p0 = pops;
        k_fv = 1; k_pc = 64'h8000_0500; tick();
        k_pc = 64'h8000_0504; tick();
        k_fv = 0;
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            if (mem_q.size() != 0 && mem_q[0].due == cyc) found = 1;
            else tick();
        end
        chk("t5_rsp_due", found, 1);
        k_flush = 1; tick(); tick();
        k_flush = 0;
        drain();
        chk("t5_pops", pops - p0, 0);
        chk("t5_iq_empty", bus.iq_empty, 1'b1);

        // Asynchronous reset mid-stream, then a fresh fetch
        k_pop = 0; rsp_lat = 3; k_fv = 1; k_pc = 64'h8000_0400;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (prev_fire) k_pc += 4;
        end
        #2 RST = 1'b1;
        #1;
        chk_reset_outputs("midrst");
        mem_q.delete(); fetch_q.delete(); sb.delete();
        prev_fire = 0;
        bus.fetch_vaild = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        @(negedge clk);
        RST = 1'b0;
        p0 = pops;
        rsp_lat = 2; k_pop = 1; k_req_rdy = 1;
        k_fv = 1; k_pc = 64'h1000; tick();
        drain();
        chk("t6_pops", pops - p0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
